preg_free_list: RTL and testbench

PREG_FREE_LIST -- requirements
Module: preg_free_list

---
 rtl/preg_free_list_if.sv | 38 +++
 rtl/preg_free_list.sv | 79 +++++++
 tb/tb_preg_free_list.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/preg_free_list_if.sv
// Purpose: rename/commit <-> physical register free list connection.
// Signals:
//   alloc_req   : rename asks for one physical register this cycle
//   alloc_valid : a free register exists (grant = alloc_req & alloc_valid)
//   alloc_preg  : lowest-numbered free register, 0 when none is free
//   free_en     : per-port release strobes from commit (ports 0 and 1)
//   free_preg0/1: indices released on ports 0 and 1
//   free_count  : number of free registers
//   free_mask   : free bitmap, bit i = 1 means register i is free
//   double_free : sticky error flag
interface preg_free_list_if #(
   parameter int unsigned NUM_PREGS = 64
);
   localparam int unsigned IDX_W = $clog2(NUM_PREGS);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic             alloc_req;
   logic             alloc_valid;
   logic [IDX_W-1:0] alloc_preg;
   logic [1:0]       free_en;
   logic [IDX_W-1:0] free_preg0;
   logic [IDX_W-1:0] free_preg1;
   logic [CNT_W-1:0] free_count;
   logic [NUM_PREGS-1:0] free_mask;
   logic             double_free;

   // Rename/commit side
   modport master (
      output alloc_req, free_en, free_preg0, free_preg1,
      input  alloc_valid, alloc_preg, free_count, free_mask, double_free
   );

   // Free list side
   modport slave (
      input  alloc_req, free_en, free_preg0, free_preg1,
      output alloc_valid, alloc_preg, free_count, free_mask, double_free
   );
endinterface

// File: rtl/preg_free_list.sv
// Purpose: physical register free list. Bitmap of free registers with a
// lowest-index-first allocator, two release ports, a running free count and
// a sticky double-free error flag.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset
//   fl    : preg_free_list_if slave modport (alloc / free / status signals)
module preg_free_list #(
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned NUM_ARCH  = 32
) (
   input  logic clk,
   input  logic reset,
   preg_free_list_if.slave fl
);
   localparam int unsigned IDX_W = $clog2(NUM_PREGS);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [NUM_PREGS-1:0] RESET_MASK  = {NUM_PREGS{1'b1}} << NUM_ARCH;
   localparam logic [CNT_W-1:0]     RESET_COUNT = CNT_W'(NUM_PREGS - NUM_ARCH);

   logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 df_q, df_d;

   logic                 valid_c;
   logic [IDX_W-1:0]     sel_c;
   logic                 grant_c;
   logic                 same_idx_c;
   logic                 f0_legal_c, f1_legal_c, dup_c;

   // Lowest-index-wins search: scanning downwards leaves the lowest set bit last
   always_comb begin
      sel_c = '0;
      for (int i = int'(NUM_PREGS) - 1; i >= 0; i--) begin
         if (bitmap_q[i]) sel_c = IDX_W'(i);
      end
   end

   assign valid_c = |bitmap_q;
   assign grant_c = fl.alloc_req & valid_c;

   // Legality is judged against the current bitmap only; a same-index pair
   // counts once as a release and once as a double free.
   assign same_idx_c = fl.free_en[0] & fl.free_en[1] & (fl.free_preg0 == fl.free_preg1);
   assign f0_legal_c = fl.free_en[0] & ~bitmap_q[fl.free_preg0];
   assign f1_legal_c = fl.free_en[1] & ~bitmap_q[fl.free_preg1] & ~same_idx_c;
   assign dup_c      = (fl.free_en[0] & bitmap_q[fl.free_preg0])
                     | (fl.free_en[1] & bitmap_q[fl.free_preg1])
                     | same_idx_c;

   // Next-state: grant clears first, then legal frees set
   always_comb begin
      bitmap_d = bitmap_q;
      if (grant_c)    bitmap_d[sel_c]          = 1'b0;
      if (f0_legal_c) bitmap_d[fl.free_preg0] = 1'b1;
      if (f1_legal_c) bitmap_d[fl.free_preg1] = 1'b1;
      count_d = count_q + CNT_W'(f0_legal_c) + CNT_W'(f1_legal_c) - CNT_W'(grant_c);
      df_d    = df_q | dup_c;
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitmap_q <= RESET_MASK;
         count_q  <= RESET_COUNT;
         df_q     <= 1'b0;
      end else begin
         bitmap_q <= bitmap_d;
         count_q  <= count_d;
         df_q     <= df_d;
      end
   end

   assign fl.alloc_valid = valid_c;
   assign fl.alloc_preg  = sel_c;
   assign fl.free_count  = count_q;
   assign fl.free_mask   = bitmap_q;
   assign fl.double_free = df_q;
endmodule

// File: tb/tb_preg_free_list.sv
// Directed vector bench for preg_free_list (NUM_PREGS=64, NUM_ARCH=32).
module tb_preg_free_list;
   logic clk;
   logic reset;

   preg_free_list_if #(.NUM_PREGS(64)) fl ();

   preg_free_list #(.NUM_PREGS(64), .NUM_ARCH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        alloc_req;
      logic [1:0]  free_en;
      logic [5:0]  p0;
      logic [5:0]  p1;
      logic        ev;
      logic [5:0]  ep;
      logic [6:0]  ec;
      logic [63:0] em;
      logic        edf;
   } vec_t;

   vec_t vecs[$];
   int   tests;
   int   failed;

   function automatic vec_t mk(input logic ar, input logic [1:0] fe, input int p0, input int p1,
                               input logic ev, input int ep, input int ec,
                               input logic [63:0] em, input logic edf);
      vec_t v;
      v.alloc_req = ar;
      v.free_en   = fe;
      v.p0        = 6'(p0);
      v.p1        = 6'(p1);
      v.ev        = ev;
      v.ep        = 6'(ep);
      v.ec        = 7'(ec);
      v.em        = em;
      v.edf       = edf;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [5:0] ep,
                            input logic [6:0] ec, input logic [63:0] em, input logic edf);
      check({tag, ".alloc_valid"}, 64'(fl.alloc_valid), 64'(ev));
      check({tag, ".alloc_preg"},  64'(fl.alloc_preg),  64'(ep));
      check({tag, ".free_count"},  64'(fl.free_count),  64'(ec));
      check({tag, ".free_mask"},   fl.free_mask,        em);
      check({tag, ".double_free"}, 64'(fl.double_free), 64'(edf));
   endtask

   task automatic drive(input logic ar, input logic [1:0] fe, input logic [5:0] p0, input logic [5:0] p1);
      fl.alloc_req  = ar;
      fl.free_en    = fe;
      fl.free_preg0 = p0;
      fl.free_preg1 = p1;
   endtask

   localparam logic [63:0] RST_MASK = 64'hFFFF_FFFF_0000_0000;

   initial begin
      logic [63:0] m;
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      drive(1'b0, 2'b00, 6'd0, 6'd0);

      // Vector table: each row is applied for one cycle, expectations are post-edge
      m = RST_MASK;
      for (int k = 0; k < 32; k++) begin
         m[32 + k] = 1'b0;
         vecs.push_back(mk(1'b1, 2'b00, 0, 0, (k < 31), (k < 31) ? 33 + k : 0, 31 - k, m, 1'b0));
      end
      vecs.push_back(mk(1'b1, 2'b00, 0, 0, 1'b0, 0, 0, 64'd0, 1'b0));
      m = '0; m[5] = 1'b1; m[40] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b11, 5, 40, 1'b1, 5, 2, m, 1'b0));
      m[5] = 1'b0;
      vecs.push_back(mk(1'b1, 2'b00, 0, 0, 1'b1, 40, 1, m, 1'b0));
      m[35] = 1'b1; m[36] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b11, 35, 36, 1'b1, 35, 3, m, 1'b0));
      m[37] = 1'b1; m[38] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b11, 37, 38, 1'b1, 35, 5, m, 1'b0));
      m[39] = 1'b1; m[41] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b11, 39, 41, 1'b1, 35, 7, m, 1'b0));
      m[42] = 1'b1; m[43] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b11, 42, 43, 1'b1, 35, 9, m, 1'b0));
      m[44] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b01, 44, 0, 1'b1, 35, 10, m, 1'b0));
      // grant 35 while freeing 3: count net unchanged
      m[35] = 1'b0; m[3] = 1'b1;
      vecs.push_back(mk(1'b1, 2'b01, 3, 0, 1'b1, 3, 10, m, 1'b0));
      m[60] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b10, 0, 60, 1'b1, 3, 11, m, 1'b0));
      // free 60 again: double free, no count change
      vecs.push_back(mk(1'b0, 2'b01, 60, 0, 1'b1, 3, 11, m, 1'b1));
      // both ports free 7: one release plus double free
      m[7] = 1'b1;
      vecs.push_back(mk(1'b0, 2'b11, 7, 7, 1'b1, 3, 12, m, 1'b1));
      vecs.push_back(mk(1'b0, 2'b00, 0, 0, 1'b1, 3, 12, m, 1'b1));
      m[3] = 1'b0;
      vecs.push_back(mk(1'b1, 2'b00, 0, 0, 1'b1, 7, 11, m, 1'b1));

      // Reset defaults, both while held and after release
      repeat (2) @(negedge clk);
      #1 check_all("rst_held", 1'b1, 6'd32, 7'd32, RST_MASK, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 check_all("rst_rel", 1'b1, 6'd32, 7'd32, RST_MASK, 1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].alloc_req, vecs[i].free_en, vecs[i].p0, vecs[i].p1);
         @(posedge clk);
         #1 check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ep, vecs[i].ec, vecs[i].em, vecs[i].edf);
      end

      // Asynchronous reset in the middle of a grant plus dual free
      @(negedge clk);
      drive(1'b1, 2'b11, 6'd3, 6'd9);
      #2 reset = 1'b1;
      #1 check_all("rst_async", 1'b1, 6'd32, 7'd32, RST_MASK, 1'b0);
      @(posedge clk);
      #1 check_all("rst_edge", 1'b1, 6'd32, 7'd32, RST_MASK, 1'b0);
      @(negedge clk);
      drive(1'b0, 2'b00, 6'd0, 6'd0);
      reset = 1'b0;
      #1 check_all("rst_after", 1'b1, 6'd32, 7'd32, RST_MASK, 1'b0);
      @(posedge clk);
      #1 check_all("rst_idle", 1'b1, 6'd32, 7'd32, RST_MASK, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
